// File: rtl/usc_rv_pkg.sv
// usc_rv_pkg: shared info-field layout, issue bundle type and divider states for the issue controller.
package usc_rv_pkg;
  localparam int USC_RV_INFO_W = 10;
  localparam int INFO_INVALID  = 9;
  localparam int INFO_EXEC     = 8;
  localparam int INFO_LSU      = 7;
  localparam int INFO_BRANCH   = 6;
  localparam int INFO_MUL      = 5;
  localparam int INFO_DIV      = 4;
  localparam int INFO_CSR      = 3;
  localparam int INFO_RDV      = 2;
  localparam int INFO_FPAGE    = 1;
  localparam int INFO_FFETCH   = 0;
  // invalid | mul | div | csr | fault_page | fault_fetch: any of these keeps a pair from dual issue
  localparam logic [USC_RV_INFO_W-1:0] INFO_NODUAL_M = 10'b10_0011_1011;
  typedef struct packed {
    logic                     vld;
    logic [31:0]              instr;
    logic [31:0]              pc;
    logic [USC_RV_INFO_W-1:0] info;
  } iss_bundle_t;
  typedef enum logic [0:0] {DIV_IDLE = 1'b0, DIV_BUSY = 1'b1} div_state_e;
endpackage

// File: rtl/usc_rv_issue_ctrl_if.sv
// usc_rv_issue_ctrl_if: fetch-queue, writeback-clear and issue-bundle signals of the issue controller.
interface usc_rv_issue_ctrl_if;
  import usc_rv_pkg::*;
  logic                     flush_i, stall_i;
  logic                     slot0_vld_i, slot1_vld_i;
  logic [31:0]              slot0_instr_i, slot1_instr_i, slot0_pc_i, slot1_pc_i;
  logic [USC_RV_INFO_W-1:0] slot0_info_i, slot1_info_i;
  logic                     slot0_pop_o, slot1_pop_o;
  logic                     wb_clr_vld_i;
  logic [4:0]               wb_clr_rd_i;
  logic                     iss0_vld_o, iss1_vld_o;
  logic [31:0]              iss0_instr_o, iss1_instr_o, iss0_pc_o, iss1_pc_o;
  logic [USC_RV_INFO_W-1:0] iss0_info_o, iss1_info_o;
  logic                     div_busy_o;
  modport slave (
    input  flush_i, stall_i, slot0_vld_i, slot1_vld_i, slot0_instr_i, slot1_instr_i,
           slot0_pc_i, slot1_pc_i, slot0_info_i, slot1_info_i, wb_clr_vld_i, wb_clr_rd_i,
    output slot0_pop_o, slot1_pop_o, iss0_vld_o, iss1_vld_o, iss0_instr_o, iss1_instr_o,
           iss0_pc_o, iss1_pc_o, iss0_info_o, iss1_info_o, div_busy_o
  );
  modport master (
    output flush_i, stall_i, slot0_vld_i, slot1_vld_i, slot0_instr_i, slot1_instr_i,
           slot0_pc_i, slot1_pc_i, slot0_info_i, slot1_info_i, wb_clr_vld_i, wb_clr_rd_i,
    input  slot0_pop_o, slot1_pop_o, iss0_vld_o, iss1_vld_o, iss0_instr_o, iss1_instr_o,
           iss0_pc_o, iss1_pc_o, iss0_info_o, iss1_info_o, div_busy_o
  );
endinterface

// File: rtl/usc_rv_scoreboard.sv
// usc_rv_scoreboard: pending-register mask; set wins over a same-cycle clear, x0 never pending.
module usc_rv_scoreboard (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [1:0]      set_vld_i,
  input  logic [1:0][4:0] set_rd_i,
  input  logic            clr_vld_i,
  input  logic [4:0]      clr_rd_i,
  input  logic [5:0][4:0] qry_rd_i,
  output logic [5:0]      qry_hit_o
);
  logic [31:0] pend_q, pend_d, set_m, clr_m;
  always_comb begin
    set_m = '0;
    clr_m = '0;
    for (int k = 0; k < 2; k++) if (set_vld_i[k]) set_m[set_rd_i[k]] = 1'b1;
    if (clr_vld_i) clr_m[clr_rd_i] = 1'b1;
    pend_d = ((pend_q & ~clr_m) | set_m) & ~32'd1;
    for (int k = 0; k < 6; k++) qry_hit_o[k] = pend_q[qry_rd_i[k]];
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) pend_q <= '0;
    else pend_q <= pend_d;
endmodule

// File: rtl/usc_rv_issue_ctrl.sv
// usc_rv_issue_ctrl: in-order issue of fetch-queue slot0 (+slot1) with scoreboard and divider occupancy.
// Dual issue is built only when USC_RV_DUAL_ISSUE_EN is defined; otherwise slot1 never pops.
module usc_rv_issue_ctrl
  import usc_rv_pkg::*;
#(
  parameter int SUPPORT_MULDIV = 1,
  parameter int DIV_LAT        = 34
) (
  input logic                clk_i,
  input logic                rstn_i,
  usc_rv_issue_ctrl_if.slave bus
);
`ifdef USC_RV_DUAL_ISSUE_EN
  localparam bit DUAL_EN = 1'b1;
`else
  localparam bit DUAL_EN = 1'b0;
`endif
  localparam bit MD = SUPPORT_MULDIV != 0;
  localparam logic [0:0] ST_IDLE = DIV_IDLE;
  localparam logic [0:0] ST_BUSY = DIV_BUSY;
  logic [USC_RV_INFO_W-1:0] inf0, inf1, inf0_iss;
  logic [4:0]               rd0, rd1;
  logic [5:0][4:0]          qry;
  logic [5:0]               hit;
  logic [1:0]               set_vld;
  logic                     div_busy, raw, dual_ok, pop0, pop1;
  iss_bundle_t              iss0_q, iss0_d, iss1_q, iss1_d;
  assign inf0 = bus.slot0_info_i;
  assign inf1 = bus.slot1_info_i;
  assign rd0  = bus.slot0_instr_i[11:7];
  assign rd1  = bus.slot1_instr_i[11:7];
  assign qry  = {rd1, bus.slot1_instr_i[24:20], bus.slot1_instr_i[19:15],
                 rd0, bus.slot0_instr_i[24:20], bus.slot0_instr_i[19:15]};
  assign raw  = inf0[INFO_RDV] && rd0 != 5'd0 && (rd0 == qry[3] || rd0 == qry[4] || rd0 == rd1);
  assign pop0 = bus.slot0_vld_i && !bus.flush_i && !bus.stall_i && !(|hit[2:0]) &&
                !(MD && inf0[INFO_DIV] && div_busy);
  assign dual_ok = bus.slot1_vld_i && !(|(inf0 & INFO_NODUAL_M)) && !(|(inf1 & INFO_NODUAL_M)) &&
                   !inf0[INFO_BRANCH] && !(inf0[INFO_LSU] && inf1[INFO_LSU]) && !raw && !(|hit[5:3]);
  assign pop1 = DUAL_EN && pop0 && dual_ok;
  assign bus.slot0_pop_o = rstn_i && pop0;
  assign bus.slot1_pop_o = rstn_i && pop1;
  assign set_vld[0] = pop0 && inf0[INFO_RDV] && (inf0[INFO_LSU] || (MD && inf0[INFO_DIV]));
  assign set_vld[1] = pop1 && inf1[INFO_RDV] && (inf1[INFO_LSU] || (MD && inf1[INFO_DIV]));
  usc_rv_scoreboard u_sb (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .set_vld_i (set_vld),
    .set_rd_i  ({rd1, rd0}),
    .clr_vld_i (bus.wb_clr_vld_i),
    .clr_rd_i  (bus.wb_clr_rd_i),
    .qry_rd_i  (qry),
    .qry_hit_o (hit)
  );
  always_comb begin
    inf0_iss = inf0;
    inf0_iss[INFO_INVALID] = inf0[INFO_INVALID] || (!MD && (inf0[INFO_MUL] || inf0[INFO_DIV]));
    iss0_d = iss0_q;
    iss1_d = iss1_q;
    if (bus.flush_i) begin
      iss0_d.vld = 1'b0;
      iss1_d.vld = 1'b0;
    end else if (!bus.stall_i) begin
      iss0_d.vld = 1'b0;
      iss1_d.vld = 1'b0;
      if (pop0) iss0_d = '{vld: 1'b1, instr: bus.slot0_instr_i, pc: bus.slot0_pc_i, info: inf0_iss};
      if (pop1) iss1_d = '{vld: 1'b1, instr: bus.slot1_instr_i, pc: bus.slot1_pc_i, info: inf1};
    end
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      iss0_q <= '0;
      iss1_q <= '0;
    end else begin
      iss0_q <= iss0_d;
      iss1_q <= iss1_d;
    end
  assign bus.iss0_vld_o   = iss0_q.vld;
  assign bus.iss0_instr_o = iss0_q.instr;
  assign bus.iss0_pc_o    = iss0_q.pc;
  assign bus.iss0_info_o  = iss0_q.info;
  assign bus.iss1_vld_o   = iss1_q.vld;
  assign bus.iss1_instr_o = iss1_q.instr;
  assign bus.iss1_pc_o    = iss1_q.pc;
  assign bus.iss1_info_o  = iss1_q.info;
  assign bus.div_busy_o   = div_busy;
  if (MD) begin : g_div
    logic [0:0] st_q, st_d;
    logic [5:0] cnt_q, cnt_d;
    // counter runs DIV_LAT-1 down to 0 while busy, giving DIV_LAT busy cycles
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (st_q == ST_IDLE) begin
        if (pop0 && inf0[INFO_DIV]) begin
          st_d  = ST_BUSY;
          cnt_d = 6'(DIV_LAT - 1);
        end
      end else begin
        st_d  = cnt_q == 6'd0 ? ST_IDLE : ST_BUSY;
        cnt_d = cnt_q == 6'd0 ? cnt_q : cnt_q - 6'd1;
      end
    end
    always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    assign div_busy = st_q == ST_BUSY;
  end else begin : g_nodiv
    assign div_busy = 1'b0;
  end
endmodule

// File: tb/tb_usc_rv_issue_ctrl.sv
// tb_usc_rv_issue_ctrl: directed vectors for the issue controller, plus a SUPPORT_MULDIV=0 shadow instance.
module tb_usc_rv_issue_ctrl;
  import usc_rv_pkg::*;
`ifdef USC_RV_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  localparam logic [9:0] ALU = 10'h104;
  localparam logic [9:0] LD  = 10'h184;
  localparam logic [9:0] DIV = 10'h114;
  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt, bad_pop;
  usc_rv_issue_ctrl_if bus ();
  usc_rv_issue_ctrl_if bus2 ();
  usc_rv_issue_ctrl dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));
  usc_rv_issue_ctrl #(.SUPPORT_MULDIV(0)) dut_nomd (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus2));
  assign bus2.flush_i       = bus.flush_i;
  assign bus2.stall_i       = bus.stall_i;
  assign bus2.slot0_vld_i   = bus.slot0_vld_i;
  assign bus2.slot1_vld_i   = bus.slot1_vld_i;
  assign bus2.slot0_instr_i = bus.slot0_instr_i;
  assign bus2.slot1_instr_i = bus.slot1_instr_i;
  assign bus2.slot0_pc_i    = bus.slot0_pc_i;
  assign bus2.slot1_pc_i    = bus.slot1_pc_i;
  assign bus2.slot0_info_i  = bus.slot0_info_i;
  assign bus2.slot1_info_i  = bus.slot1_info_i;
  assign bus2.wb_clr_vld_i  = bus.wb_clr_vld_i;
  assign bus2.wb_clr_rd_i   = bus.wb_clr_rd_i;
  always #5 clk_i = ~clk_i;
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "bench stopped");
  end
  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic slots(input logic v0, input logic [31:0] i0, input logic [9:0] f0,
                       input logic v1, input logic [31:0] i1, input logic [9:0] f1, input logic [31:0] pc);
    bus.slot0_vld_i   = v0;
    bus.slot0_instr_i = i0;
    bus.slot0_info_i  = f0;
    bus.slot1_vld_i   = v1;
    bus.slot1_instr_i = i1;
    bus.slot1_info_i  = f1;
    bus.slot0_pc_i    = pc;
    bus.slot1_pc_i    = pc + 32'd4;
    #1;
  endtask
  initial begin
    bus.flush_i      = 1'b0;
    bus.stall_i      = 1'b0;
    bus.wb_clr_vld_i = 1'b0;
    bus.wb_clr_rd_i  = 5'd0;
    slots(1, rtype(1, 2, 3), ALU, 1, rtype(2, 3, 4), ALU, 32'h100);
    @(posedge clk_i);
    #2;
    check("rst_pop0", bus.slot0_pop_o, 0);
    check("rst_pop1", bus.slot1_pop_o, 0);
    check("rst_iss0_vld", bus.iss0_vld_o, 0);
    check("rst_iss0_instr", bus.iss0_instr_o, 0);
    check("rst_busy", bus.div_busy_o, 0);
    bus.slot0_vld_i = 1'b0;
    bus.slot1_vld_i = 1'b0;
    #1 rstn_i = 1'b1;
    // independent add pair
    step();
    slots(1, rtype(1, 2, 3), ALU, 1, rtype(2, 3, 4), ALU, 32'h100);
    check("a_pop0", bus.slot0_pop_o, 1);
    check("a_pop1", bus.slot1_pop_o, DUAL);
    step();
    slots(1, rtype(5, 1, 2), ALU, 1, rtype(6, 5, 0), ALU, 32'h200);
    check("a_iss0_vld", bus.iss0_vld_o, 1);
    check("a_iss0_instr", bus.iss0_instr_o, rtype(1, 2, 3));
    check("a_iss0_pc", bus.iss0_pc_o, 32'h100);
    check("a_iss1_vld", bus.iss1_vld_o, DUAL);
    check("a_iss1_instr", bus.iss1_instr_o, DUAL ? rtype(2, 3, 4) : 32'd0);
    check("a_iss1_pc", bus.iss1_pc_o, DUAL ? 32'h104 : 32'd0);
    check("b_pop0", bus.slot0_pop_o, 1);
    check("b_pop1_raw", bus.slot1_pop_o, 0);
    step();
    slots(1, rtype(6, 5, 0), ALU, 0, 32'd0, 10'd0, 32'h204);
    check("b_iss0_instr", bus.iss0_instr_o, rtype(5, 1, 2));
    check("b_iss1_vld", bus.iss1_vld_o, 0);
    check("b2_pop0", bus.slot0_pop_o, 1);
    // load x7, dependent add waits for writeback clear
    step();
    slots(1, rtype(7, 1, 0), LD, 0, 32'd0, 10'd0, 32'h300);
    check("b2_iss0_instr", bus.iss0_instr_o, rtype(6, 5, 0));
    check("c_ld_pop", bus.slot0_pop_o, 1);
    step();
    slots(1, rtype(8, 7, 1), ALU, 0, 32'd0, 10'd0, 32'h304);
    check("c_iss0_ld", bus.iss0_instr_o, rtype(7, 1, 0));
    check("c_hz_pop", bus.slot0_pop_o, 0);
    step();
    check("c_hz_iss_vld", bus.iss0_vld_o, 0);
    check("c_hz_pop2", bus.slot0_pop_o, 0);
    step();
    bus.wb_clr_vld_i = 1'b1;
    bus.wb_clr_rd_i  = 5'd7;
    #1;
    check("c_clr_cycle_pop", bus.slot0_pop_o, 0);
    step();
    bus.wb_clr_vld_i = 1'b0;
    #1;
    check("c_after_clr_pop", bus.slot0_pop_o, 1);
    step();
    check("c_iss0_dep", bus.iss0_instr_o, rtype(8, 7, 1));
    // set and clear of x9 in the same cycle keeps x9 pending
    bus.wb_clr_vld_i = 1'b1;
    bus.wb_clr_rd_i  = 5'd9;
    slots(1, rtype(9, 1, 0), LD, 0, 32'd0, 10'd0, 32'h400);
    check("s_ld9_pop", bus.slot0_pop_o, 1);
    step();
    bus.wb_clr_vld_i = 1'b0;
    slots(1, rtype(10, 9, 0), ALU, 0, 32'd0, 10'd0, 32'h404);
    check("s_setclr_pop", bus.slot0_pop_o, 0);
    step();
    bus.wb_clr_vld_i = 1'b1;
    #1;
    step();
    bus.wb_clr_vld_i = 1'b0;
    #1;
    check("s_cleared_pop", bus.slot0_pop_o, 1);
    step();
    slots(1, rtype(0, 1, 0), LD, 0, 32'd0, 10'd0, 32'h500);
    check("x0_ld_pop", bus.slot0_pop_o, 1);
    step();
    slots(1, rtype(11, 0, 0), ALU, 0, 32'd0, 10'd0, 32'h504);
    check("x0_no_hz_pop", bus.slot0_pop_o, 1);
    // divider occupancy
    step();
    slots(1, rtype(10, 1, 2), DIV, 0, 32'd0, 10'd0, 32'h600);
    check("d_pop", bus.slot0_pop_o, 1);
    check("nomd_d_pop", bus2.slot0_pop_o, 1);
    step();
    slots(1, rtype(11, 1, 2), DIV, 0, 32'd0, 10'd0, 32'h604);
    check("d_iss0_info", bus.iss0_info_o, DIV);
    check("nomd_iss0_info", bus2.iss0_info_o, 10'h314);
    check("nomd_busy", bus2.div_busy_o, 0);
    busy_cnt = 0;
    bad_pop  = 0;
    while (bus.div_busy_o && busy_cnt < 100) begin
      if (bus.slot0_pop_o) bad_pop++;
      busy_cnt++;
      @(posedge clk_i);
      #2;
    end
    check("d_busy_cycles", busy_cnt, 34);
    check("d_pop_while_busy", bad_pop, 0);
    check("d_pop_after_busy", bus.slot0_pop_o, 1);
    step();
    check("d2_busy", bus.div_busy_o, 1);
    slots(1, rtype(12, 1, 2), LD, 0, 32'd0, 10'd0, 32'h700);
    check("d2_ld_pop", bus.slot0_pop_o, 1);
    step();
    slots(1, rtype(13, 12, 0), ALU, 0, 32'd0, 10'd0, 32'h704);
    check("r_hz_pop", bus.slot0_pop_o, 0);
    // asynchronous reset mid-divide
    #2 rstn_i = 1'b0;
    #1;
    check("r_busy", bus.div_busy_o, 0);
    check("r_pop", bus.slot0_pop_o, 0);
    check("r_iss0_vld", bus.iss0_vld_o, 0);
    #2 rstn_i = 1'b1;
    #1;
    check("r_pop_after", bus.slot0_pop_o, 1);
    // stall holds, flush kills
    step();
    slots(1, rtype(14, 1, 2), ALU, 0, 32'd0, 10'd0, 32'h800);
    check("e_pop", bus.slot0_pop_o, 1);
    step();
    bus.stall_i = 1'b1;
    slots(1, rtype(15, 1, 2), ALU, 0, 32'd0, 10'd0, 32'h804);
    check("e_stall_pop", bus.slot0_pop_o, 0);
    check("e_iss0_vld", bus.iss0_vld_o, 1);
    check("e_iss0_instr", bus.iss0_instr_o, rtype(14, 1, 2));
    step();
    check("e_hold_vld", bus.iss0_vld_o, 1);
    check("e_hold_instr", bus.iss0_instr_o, rtype(14, 1, 2));
    bus.flush_i = 1'b1;
    #1;
    check("e_flush_pop", bus.slot0_pop_o, 0);
    step();
    check("e_flush_vld", bus.iss0_vld_o, 0);
    check("e_flush_vld1", bus.iss1_vld_o, 0);
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    #1;
    check("e_resume_pop", bus.slot0_pop_o, 1);
    step();
    check("e_resume_vld", bus.iss0_vld_o, 1);
    check("e_resume_instr", bus.iss0_instr_o, rtype(15, 1, 2));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
